// File: rtl/ioctl_dn_ctrl.sv
// ioctl_dn_ctrl
//
// Purpose: buffers bytes coming from an ioctl download master in a small
// FIFO and replays them as one-cycle writes to a target memory port. The
// target system is held in reset for the whole download. It stays in reset
// until the buffer has drained plus RESET_HOLD cycles.
//
// Ports:
//   clk_sys        in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   ioctl_download in   download in progress
//   ioctl_wr       in   one-cycle write strobe from the download master
//   ioctl_addr     in   [24:0] download byte address
//   ioctl_dout     in   [7:0]  download byte
//   ioctl_index    in   [7:0]  download target index
//   ioctl_wait     out  registered stall request to the download master
//   mem_busy       in   target port owned by another requester this cycle
//   dn_wr          out  registered one-cycle write strobe to the target
//   dn_addr        out  [ADDR_W-1:0] write address (valid with dn_wr)
//   dn_data        out  [7:0] write data (valid with dn_wr)
//   dn_index       out  [7:0] write index (valid with dn_wr)
//   sys_reset      out  registered system reset, low only in IDLE
//   err_range      out  sticky: an accepted write had an out-of-range address
//   err_ovf        out  sticky: an accepted write was dropped, buffer full
//   dbg_state      out  [1:0] current FSM state (IDLE=0 LOAD=1 DRAIN=2 HOLD=3)
//
// Flow control: a write is taken on a clock edge where ioctl_wr=1 and
// ioctl_download=1. The master has no per-write ready. ioctl_wait is advisory
// and rises once the buffer is one entry short of full. A write that arrives
// while the buffer is full, with no pop on the same edge, is dropped and
// flagged in err_ovf. On the target side, mem_busy=1 means no pop on that
// edge. Every popped entry appears on the dn_* outputs with dn_wr=1 for
// exactly one cycle.

module ioctl_dn_ctrl #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 14,
  parameter int RESET_HOLD = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic              ioctl_wait,
  input  logic              mem_busy,
  output logic              dn_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic [7:0]        dn_index,
  output logic              sys_reset,
  output logic              err_range,
  output logic              err_ovf,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + 16;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [7:0]       HOLD_P  = 8'(RESET_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_q, state_next;
  logic [7:0] hold_cnt_q;

  // ---------------------------------------------------------------- FIFO
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, count_q, count_next;
  logic wr_accept, addr_ok, push_try, push, pop, full, empty;
  logic range_hit, ovf_hit;

  assign wr_accept = ioctl_wr & ioctl_download;
  // Out of range when any address bit at or above ADDR_W is set.
  assign addr_ok   = (ioctl_addr >> ADDR_W) == 25'd0;
  assign full      = count_q == DEPTH_P;
  assign empty     = count_q == '0;
  assign pop       = ~empty & ~mem_busy;
  assign push_try  = wr_accept & addr_ok;
  // At full, a push still fits when an entry leaves on the same edge.
  assign push      = push_try & (~full | pop);
  assign range_hit = wr_accept & ~addr_ok;
  assign ovf_hit   = push_try & full & ~pop;
  assign count_next = count_q + PTR_W'(push) - PTR_W'(pop);

  // Storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr_q[PTR_W-2:0]] <= {ioctl_addr[ADDR_W-1:0], ioctl_dout, ioctl_index};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ioctl_wait <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_index   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_next;
      ioctl_wait <= count_next >= (DEPTH_P - PTR_W'(1));
      dn_wr      <= pop;
      if (pop) begin
        {dn_addr, dn_data, dn_index} <= mem[rd_ptr_q[PTR_W-2:0]];
      end
    end
  end

  // ------------------------------------------------------- state register
  logic sys_reset_d, err_clr;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      sys_reset  <= 1'b1;
      err_range  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state_q <= state_next;
      // The counter only runs while HOLD persists. Any exit clears it, so
      // the next entry into HOLD starts from zero.
      if (state_q == HOLD && state_next == HOLD) hold_cnt_q <= hold_cnt_q + 8'd1;
      else                                       hold_cnt_q <= '0;
      sys_reset <= sys_reset_d;
      // A new error on the clearing edge still wins.
      err_range <= (err_range & ~err_clr) | range_hit;
      err_ovf   <= (err_ovf & ~err_clr) | ovf_hit;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (ioctl_download) state_next = LOAD;
      LOAD:    if (!ioctl_download) state_next = DRAIN;
      DRAIN:   if (empty) state_next = HOLD;
      HOLD: begin
        if (ioctl_download)                   state_next = LOAD;
        else if (hold_cnt_q + 8'd1 == HOLD_P) state_next = IDLE;
      end
      default: state_next = HOLD;
    endcase
  end

  // --------------------------------------------------------------- outputs
  // sys_reset is registered from the next state, so it tracks state_q
  // exactly and has no combinational path to the outputs.
  always_comb begin
    sys_reset_d = 1'b1;
    err_clr     = 1'b0;
    if (state_next == IDLE)                   sys_reset_d = 1'b0;
    if (state_q == IDLE && state_next == LOAD) err_clr    = 1'b1;
  end

  assign dbg_state = state_q;

endmodule
